// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: forwarding-select encodings and the scoreboard entry record,
// used by the hazard unit and by the datapath operand muxes.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FwdRegfile = 2'b00,
        FwdEx      = 2'b01,
        FwdMem     = 2'b10,
        FwdWb      = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       reg_write;
        logic       is_load;
    } sb_entry_t;

    // r15 is the PC and is never forwarded.
    localparam logic [3:0] RegPc = 4'd15;

    function automatic logic fwd_hit(input sb_entry_t e, input logic [3:0] r);
        return e.valid && e.reg_write && (e.rd == r);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-stage in-flight destination tracker (EX, MEM, WB) mirroring the pipeline registers.
module hazard_scoreboard
    import hazard_unit_pkg::*;
(
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      ex_load_i,
    input  sb_entry_t id_entry_i,
    output sb_entry_t ex_o,
    output sb_entry_t mem_o,
    output sb_entry_t wb_o
);

    sb_entry_t ex_d, ex_q;
    sb_entry_t mem_d, mem_q;
    sb_entry_t wb_d, wb_q;

    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = id_entry_i;
        // A bubble or an empty decode slot enters EX as an invalid entry.
        if (!ex_load_i) begin
            ex_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall detection, taken-branch flush and operand forwarding selection for a
// five-stage pipeline, plus a saturating count of load-use stall cycles.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [3:0]             id_rn,
    input  logic [3:0]             id_rm,
    input  logic                   id_rn_used,
    input  logic                   id_rm_used,
    input  logic [3:0]             id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_is_load,
    input  logic                   branch_taken,
    output logic                   cu_mux_select,
    output logic                   pc_load_enable,
    output logic                   if_id_load_enable,
    output logic                   if_id_flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CntOne = STALL_CNT_W'(1);

    sb_entry_t id_entry, ex_e, mem_e, wb_e;
    logic      load_use;
    logic      stall;
    fwd_sel_e  fwd_a, fwd_b;

    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    assign id_entry = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                        is_load: id_is_load};

    hazard_scoreboard u_scoreboard (
        .clk_i      (clk),
        .reset_i    (reset),
        .ex_load_i  (cu_mux_select && id_valid),
        .id_entry_i (id_entry),
        .ex_o       (ex_e),
        .mem_o      (mem_e),
        .wb_o       (wb_e)
    );

    function automatic fwd_sel_e pick_fwd(input logic [3:0] r, input logic used,
                                          input sb_entry_t ex, input sb_entry_t mem,
                                          input sb_entry_t wb);
        if (!used || r == RegPc) begin
            return FwdRegfile;
        end
        // A load in EX has no data yet; the load-use stall covers that case.
        if (fwd_hit(ex, r) && !ex.is_load) begin
            return FwdEx;
        end
        if (fwd_hit(mem, r)) begin
            return FwdMem;
        end
        if (fwd_hit(wb, r)) begin
            return FwdWb;
        end
        return FwdRegfile;
    endfunction

    always_comb begin
        load_use = id_valid && ex_e.valid && ex_e.is_load && ex_e.reg_write &&
                   ((id_rn_used && id_rn == ex_e.rd) || (id_rm_used && id_rm == ex_e.rd));
        stall    = !reset && load_use && !branch_taken;

        fwd_a = pick_fwd(id_rn, id_rn_used, ex_e, mem_e, wb_e);
        fwd_b = pick_fwd(id_rm, id_rm_used, ex_e, mem_e, wb_e);

        cu_mux_select     = 1'b1;
        pc_load_enable    = 1'b1;
        if_id_load_enable = 1'b1;
        if_id_flush       = 1'b0;
        fwd_a_sel         = fwd_a;
        fwd_b_sel         = fwd_b;

        if (reset) begin
            cu_mux_select     = 1'b0;
            pc_load_enable    = 1'b0;
            if_id_load_enable = 1'b0;
            fwd_a_sel         = FwdRegfile;
            fwd_b_sel         = FwdRegfile;
        end else if (branch_taken) begin
            cu_mux_select = 1'b0;
            if_id_flush   = 1'b1;
        end else if (load_use) begin
            cu_mux_select     = 1'b0;
            pc_load_enable    = 1'b0;
            if_id_load_enable = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a queue-based reference model predicts every cycle's outputs
// and a negedge monitor compares them; directed scenarios add spot checks on named values.
module tb_hazard_unit;

    localparam int W      = 4;
    localparam int CntMax = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         id_valid, id_rn_used, id_rm_used, id_reg_write, id_is_load, branch_taken;
    logic [3:0]   id_rn, id_rm, id_rd;
    logic         cu_mux_select, pc_load_enable, if_id_load_enable, if_id_flush;
    logic [1:0]   fwd_a_sel, fwd_b_sel;
    logic [W-1:0] stall_count;

    hazard_unit #(.STALL_CNT_W(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .id_valid          (id_valid),
        .id_rn             (id_rn),
        .id_rm             (id_rm),
        .id_rn_used        (id_rn_used),
        .id_rm_used        (id_rm_used),
        .id_rd             (id_rd),
        .id_reg_write      (id_reg_write),
        .id_is_load        (id_is_load),
        .branch_taken      (branch_taken),
        .cu_mux_select     (cu_mux_select),
        .pc_load_enable    (pc_load_enable),
        .if_id_load_enable (if_id_load_enable),
        .if_id_flush       (if_id_flush),
        .fwd_a_sel         (fwd_a_sel),
        .fwd_b_sel         (fwd_b_sel),
        .stall_count       (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst; bit v; int rn; bit rnu; int rm; bit rmu; int rd; bit we; bit ld; bit br;
    } stim_t;

    typedef struct {
        int cu; int pc; int ifid; int flush; int fa; int fb; int cnt;
    } exp_t;

    typedef struct { bit valid; int rd; bit we; bit ld; } ent_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    exp_t  exp_q[$];
    ent_t  hist[$];   // hist[0] = youngest in-flight instruction (EX), hist[2] = oldest (WB)
    int    cnt;
    stim_t cur;
    exp_t  cur_exp;
    bit    cur_stall;

    function automatic stim_t mk(bit v, int rn, bit rnu, int rm, bit rmu, int rd, bit we,
                                 bit ld, bit br, bit rst = 1'b0);
        stim_t s;
        s.rst = rst; s.v = v; s.rn = rn; s.rnu = rnu; s.rm = rm; s.rmu = rmu;
        s.rd = rd; s.we = we; s.ld = ld; s.br = br;
        return s;
    endfunction

    function automatic stim_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic model_clear();
        ent_t e;
        e.valid = 0; e.rd = 0; e.we = 0; e.ld = 0;
        hist.delete();
        repeat (3) hist.push_back(e);
        cnt = 0;
    endtask

    function automatic int model_fwd(int r, bit used, bit rst);
        if (rst || !used || r == 15) return 0;
        for (int age = 0; age < 3; age++) begin
            if (hist[age].valid && hist[age].we && hist[age].rd == r) begin
                if (!(age == 0 && hist[age].ld)) return age + 1;
            end
        end
        return 0;
    endfunction

    // Advance the model across the clock edge that just occurred, using the previous inputs.
    task automatic model_edge();
        ent_t e;
        if (cur.rst) begin
            model_clear();
        end else begin
            e.valid = (cur_exp.cu == 1) && cur.v;
            e.rd = cur.rd; e.we = cur.we; e.ld = cur.ld;
            hist.push_front(e);
            void'(hist.pop_back());
            if (cur_stall) cnt = (cnt >= CntMax) ? CntMax : cnt + 1;
        end
    endtask

    task automatic model_outputs(input stim_t s, output exp_t x, output bit stl);
        bit hz;
        hz = s.v && hist[0].valid && hist[0].ld && hist[0].we &&
             ((s.rnu && s.rn == hist[0].rd) || (s.rmu && s.rm == hist[0].rd));
        stl = 0;
        if (s.rst) begin
            x.cu = 0; x.pc = 0; x.ifid = 0; x.flush = 0;
        end else if (s.br) begin
            x.cu = 0; x.pc = 1; x.ifid = 1; x.flush = 1;
        end else if (hz) begin
            x.cu = 0; x.pc = 0; x.ifid = 0; x.flush = 0;
            stl = 1;
        end else begin
            x.cu = 1; x.pc = 1; x.ifid = 1; x.flush = 0;
        end
        x.fa  = model_fwd(s.rn, s.rnu, s.rst);
        x.fb  = model_fwd(s.rm, s.rmu, s.rst);
        x.cnt = cnt;
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        if (s.rst) model_clear();
        reset        = s.rst;
        id_valid     = s.v;
        id_rn        = 4'(s.rn);
        id_rn_used   = s.rnu;
        id_rm        = 4'(s.rm);
        id_rm_used   = s.rmu;
        id_rd        = 4'(s.rd);
        id_reg_write = s.we;
        id_is_load   = s.ld;
        branch_taken = s.br;
        cur = s;
        model_outputs(s, cur_exp, cur_stall);
        exp_q.push_back(cur_exp);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set, compared against the queue head.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_cmp++;
                if (cu_mux_select !== 1'(x.cu) || pc_load_enable !== 1'(x.pc) ||
                    if_id_load_enable !== 1'(x.ifid) || if_id_flush !== 1'(x.flush) ||
                    fwd_a_sel !== 2'(x.fa) || fwd_b_sel !== 2'(x.fb) ||
                    stall_count !== W'(x.cnt)) begin
                    n_bad++;
                    $display("FAIL outputs@cyc%0d: got cu=%b pc=%b ifid=%b fl=%b fa=%b fb=%b cnt=%0d, expected cu=%0d pc=%0d ifid=%0d fl=%0d fa=%0d fb=%0d cnt=%0d",
                             cyc, cu_mux_select, pc_load_enable, if_id_load_enable, if_id_flush,
                             fwd_a_sel, fwd_b_sel, stall_count, x.cu, x.pc, x.ifid, x.flush,
                             x.fa, x.fb, x.cnt);
                end
            end
        end
    end

    initial begin
        int gap_exp[4];
        stim_t s;
        gap_exp[0] = 1; gap_exp[1] = 2; gap_exp[2] = 3; gap_exp[3] = 0;

        reset = 1'b1; id_valid = 0; id_rn = 0; id_rm = 0; id_rn_used = 0; id_rm_used = 0;
        id_rd = 0; id_reg_write = 0; id_is_load = 0; branch_taken = 0;
        model_clear();
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_outputs(cur, cur_exp, cur_stall);

        // Reset state.
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        chk("reset_cu", int'(cu_mux_select), 0);
        chk("reset_pc", int'(pc_load_enable), 0);
        chk("reset_cnt", int'(stall_count), 0);
        step(nop());

        // LDR r3 then ADD rn=r3: one stall, then MEM forward.
        step(mk(1, 1, 1, 0, 0, 3, 1, 1, 0));
        step(mk(1, 3, 1, 4, 1, 5, 1, 0, 0));
        @(negedge clk);
        chk("ldr_use_cu", int'(cu_mux_select), 0);
        chk("ldr_use_pc", int'(pc_load_enable), 0);
        chk("ldr_use_ifid", int'(if_id_load_enable), 0);
        step(mk(1, 3, 1, 4, 1, 5, 1, 0, 0));
        @(negedge clk);
        chk("ldr_use_cnt", int'(stall_count), 1);
        chk("ldr_use_fwd_a", int'(fwd_a_sel), 2);
        chk("ldr_use_cu_after", int'(cu_mux_select), 1);

        // ADD r2 then SUB rm=r2 with 0..3 independent instructions between.
        for (int gap = 0; gap < 4; gap++) begin
            repeat (3) step(nop());
            step(mk(1, 0, 1, 1, 1, 2, 1, 0, 0));
            for (int k = 0; k < gap; k++) step(mk(1, 0, 1, 1, 1, 7, 1, 0, 0));
            step(mk(1, 5, 1, 2, 1, 6, 1, 0, 0));
            @(negedge clk);
            chk($sformatf("fwd_b_gap%0d", gap), int'(fwd_b_sel), gap_exp[gap]);
        end

        // Load-use coinciding with a taken branch: flush wins, no stall counted.
        step(mk(1, 1, 1, 0, 0, 3, 1, 1, 0));
        step(mk(1, 3, 1, 0, 0, 5, 1, 0, 1));
        @(negedge clk);
        chk("br_flush", int'(if_id_flush), 1);
        chk("br_pc", int'(pc_load_enable), 1);
        chk("br_cu", int'(cu_mux_select), 0);
        step(nop());
        @(negedge clk);
        chk("br_cnt", int'(stall_count), 1);

        // r15 and unused-operand matches never forward or stall.
        step(mk(1, 0, 0, 0, 0, 15, 1, 0, 0));
        step(mk(1, 15, 1, 15, 1, 6, 1, 0, 0));
        @(negedge clk);
        chk("r15_fwd_a", int'(fwd_a_sel), 0);
        step(mk(1, 1, 1, 0, 0, 4, 1, 1, 0));
        step(mk(1, 4, 0, 0, 0, 6, 1, 0, 0));
        @(negedge clk);
        chk("unused_cu", int'(cu_mux_select), 1);
        chk("unused_fwd_a", int'(fwd_a_sel), 0);

        // Back-to-back dependent loads each stall once.
        step(mk(1, 1, 1, 0, 0, 3, 1, 1, 0));
        step(mk(1, 3, 1, 0, 0, 4, 1, 1, 0));
        step(mk(1, 3, 1, 0, 0, 4, 1, 1, 0));
        step(mk(1, 4, 1, 0, 0, 5, 1, 0, 0));
        step(mk(1, 4, 1, 0, 0, 5, 1, 0, 0));
        @(negedge clk);
        chk("b2b_cnt", int'(stall_count), 3);

        // Reset asserted in the middle of a stall aborts it at once.
        step(mk(1, 1, 1, 0, 0, 3, 1, 1, 0));
        step(mk(1, 3, 1, 0, 0, 5, 1, 0, 0, 1));
        @(negedge clk);
        chk("rst_mid_cu", int'(cu_mux_select), 0);
        chk("rst_mid_pc", int'(pc_load_enable), 0);
        chk("rst_mid_cnt", int'(stall_count), 0);
        step(mk(1, 3, 1, 0, 0, 5, 1, 0, 0));
        @(negedge clk);
        chk("post_rst_cu", int'(cu_mux_select), 1);

        // Saturation: 2^W + 3 forced stalls.
        for (int i = 0; i < (1 << W) + 3; i++) begin
            step(mk(1, 1, 1, 0, 0, 3, 1, 1, 0));
            step(mk(1, 3, 1, 0, 0, 5, 1, 0, 0));
        end
        step(nop());
        @(negedge clk);
        chk("sat_cnt", int'(stall_count), CntMax);

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            s.rst = ($urandom_range(0, 99) < 2);
            s.v   = ($urandom_range(0, 9) != 0);
            s.rn  = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            s.rm  = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            s.rd  = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            s.rnu = ($urandom_range(0, 3) != 0);
            s.rmu = ($urandom_range(0, 1) != 0);
            s.we  = ($urandom_range(0, 4) != 0);
            s.ld  = ($urandom_range(0, 2) == 0);
            s.br  = ($urandom_range(0, 9) == 0);
            step(s);
        end

        step(nop());
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the saturating stall-cycle counter.
REQ-002 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset (one clock domain; polarity and synchronicity fixed).
REQ-004 SHALL have port id_valid  in  1  decode-stage slot holds a real instruction.
REQ-005 SHALL have ports id_rn, id_rm  in  4 each  decode-stage source register numbers.
REQ-006 SHALL have ports id_rn_used, id_rm_used  in  1 each  source is actually read.
REQ-007 SHALL have ports id_rd  in  4, id_reg_write  in  1, id_is_load  in  1  decode-stage destination info.
REQ-008 SHALL have port branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-009 SHALL have port cu_mux_select  out  1  1 = pass decoded control signals into ID/EX; 0 = insert bubble (all controls zeroed).
REQ-010 SHALL have ports pc_load_enable, if_id_load_enable  out  1 each  PC / IF-ID register update enables.
REQ-011 SHALL have port if_id_flush  out  1  clear IF/ID to a NOP on the next edge.
REQ-012 SHALL have ports fwd_a_sel, fwd_b_sel  out  2 each  operand source for rn / rm: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-013 SHALL have port stall_count  out  STALL_CNT_W  number of load-use stall cycles since reset.

Function
REQ-014 SHALL keep an internal 3-entry scoreboard (EX, MEM, WB), each entry {valid, rd, reg_write, is_load}.
REQ-015 Each clock SHALL shift WB<=MEM, MEM<=EX; EX<=ID info when cu_mux_select=1 and id_valid=1, otherwise EX.valid<=0.
REQ-016 Load-use hazard SHALL be: id_valid & EX.valid & EX.is_load & EX.reg_write & ((id_rn_used & id_rn==EX.rd) | (id_rm_used & id_rm==EX.rd)).
REQ-017 On a load-use hazard with branch_taken=0: cu_mux_select=0, pc_load_enable=0, if_id_load_enable=0, if_id_flush=0, for exactly 1 cycle per hazard.
REQ-018 The stall SHALL self-clear on the next cycle, because the load moves to MEM and the bubble occupies EX.
REQ-019 On branch_taken=1: cu_mux_select=0, if_id_flush=1, pc_load_enable=1, if_id_load_enable=1, regardless of any hazard (branch has priority).
REQ-020 With no hazard and no branch: cu_mux_select=1, pc_load_enable=1, if_id_load_enable=1, if_id_flush=0.
REQ-021 Forward select per operand SHALL use the youngest matching valid reg_write entry, priority EX > MEM > WB, otherwise 00.
REQ-022 EX SHALL NOT be selected when EX.is_load=1; the stall covers that case.
REQ-023 Register 15 and unused operands (id_*_used=0) SHALL always select 00.
REQ-024 All control outputs SHALL be combinational from the scoreboard and inputs, with no added latency.
REQ-025 stall_count SHALL increment by 1 on each edge where REQ-017 applies.
REQ-026 stall_count SHALL saturate at all-ones.
REQ-027 Back-to-back loads SHALL each produce their own single stall cycle when dependent.

Reset
REQ-028 While reset=1: all scoreboard entries invalid, stall_count=0.
REQ-029 While reset=1: cu_mux_select=0, pc_load_enable=0, if_id_load_enable=0, if_id_flush=0, fwd_a_sel=fwd_b_sel=00.
REQ-030 Reset asserted during a stall or flush SHALL abort it immediately.
REQ-031 After reset deasserts, the first edge SHALL begin normal operation with no residual hazard.

Structure
REQ-032 Forward-select encodings and the scoreboard entry record SHALL live in a shared pipeline package, also used by the datapath forwarding muxes.
REQ-033 The scoreboard SHALL be a sub-module named hazard_scoreboard; detection and forwarding logic stays in hazard_unit.

Verification
REQ-034 LDR r3 then ADD using rn=r3:
- required response: exactly 1 cycle with cu_mux_select=0, pc_load_enable=0, if_id_load_enable=0, stall_count 0->1;
- next cycle: fwd_a_sel=10.
REQ-035 ADD r2 then SUB using rm=r2, back-to-back -> no stall, fwd_b_sel=01.
REQ-036 Same as REQ-035 with 1 independent instruction between -> fwd_b_sel=10; with 2 between -> 11; with 3 between -> 00.
REQ-037 Load-use hazard and branch_taken in the same cycle -> if_id_flush=1, pc_load_enable=1, cu_mux_select=0, stall_count unchanged.
REQ-038 Dependence on r15, or id_rn_used=0 with matching id_rn -> fwd select 00, no stall.
REQ-039 Reset pulsed mid-stall -> outputs at reset values within the same cycle, stall_count=0.
REQ-040 Forced 2^STALL_CNT_W+3 stalls -> stall_count holds at all-ones.
